codec_init_sequencer: RTL and testbench

- Sequencer that configures the audio codec over I2C after power-up.
- Walks a fixed table of 16-bit codec register words (7-bit register address plus 9-bit data).
- Issues one 3-byte write per entry to the I2C write engine through a start/done handshake.
- Retries NACKed writes, then reports init_done or init_error to the top level, which gates the audio datapath.

---
 rtl/codec_init_pkg.sv | 29 ++
 rtl/codec_init_rom.sv | 27 ++
 rtl/codec_init_sequencer.sv | 172 +++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_init_pkg.sv
// Shared types and constants for the codec power-up configuration sequencer.
// Register addresses follow the codec's 7-bit control-port register map.
package codec_init_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PWR_WAIT = 3'd1,
    ISSUE    = 3'd2,
    WAIT     = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5,
    ERROR    = 3'd6
  } state_t;

  localparam logic [6:0] LINVOL = 7'h00;
  localparam logic [6:0] RINVOL = 7'h01;
  localparam logic [6:0] LHPOUT = 7'h02;
  localparam logic [6:0] RHPOUT = 7'h03;
  localparam logic [6:0] APATH  = 7'h04;
  localparam logic [6:0] DPATH  = 7'h05;
  localparam logic [6:0] PWRDN  = 7'h06;
  localparam logic [6:0] DAIF   = 7'h07;
  localparam logic [6:0] SAMPLE = 7'h08;
  localparam logic [6:0] ACTIVE = 7'h09;
  localparam logic [6:0] RESET  = 7'h0F;

  localparam int TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/codec_init_rom.sv
// Fixed codec bring-up table: index -> {reg_addr[6:0], data[8:0]}.
module codec_init_rom
  import codec_init_pkg::*;
(
  input  logic [4:0]  i_index,
  output logic [15:0] o_word
);

  // Volume and headphone writes set the "both channels" bit, so right follows left.
  always_comb begin
    o_word = 16'h0000;
    case (i_index)
      5'd0:    o_word = {RESET,  9'h000};
      5'd1:    o_word = {PWRDN,  9'h000};
      5'd2:    o_word = {LINVOL, 9'h117};
      5'd3:    o_word = {RINVOL, 9'h017};
      5'd4:    o_word = {LHPOUT, 9'h179};
      5'd5:    o_word = {APATH,  9'h012};
      5'd6:    o_word = {DPATH,  9'h000};
      5'd7:    o_word = {DAIF,   9'h042};
      5'd8:    o_word = {SAMPLE, 9'h000};
      5'd9:    o_word = {ACTIVE, 9'h001};
      default: o_word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec init table, one I2C write per entry, with NACK retries.
// Optional CODEC_INIT_TIMEOUT_EN: a missing i2c_done in WAIT is treated as a NACK.
//
// state    | meaning
// IDLE     | waiting for start after reset
// PWR_WAIT | codec power-up settling delay
// ISSUE    | i2c_start pulse for the current entry
// WAIT     | transaction in flight, bus outputs held
// GAP      | bus free time, then next/retry/finish decision
// DONE     | all entries ACKed
// ERROR    | an entry exhausted its retries
module codec_init_sequencer
  import codec_init_pkg::*;
#(
  parameter int         NUM_REGS        = 10,
  parameter logic [7:0] DEV_ADDR        = 8'h34,
  parameter int         PWR_WAIT_CYCLES = 50000,
  parameter int         GAP_CYCLES      = 256,
  parameter int         MAX_RETRIES     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        i2c_start,
  output logic [7:0]  i2c_dev,
  output logic [15:0] i2c_word,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic        busy,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  cur_index
);

  localparam int MAX_WAIT = (PWR_WAIT_CYCLES > GAP_CYCLES) ? PWR_WAIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int IDX_W    = $clog2(NUM_REGS + 1);

  localparam logic [CNT_W-1:0] PWR_LOAD  = CNT_W'(PWR_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS);
  localparam logic [2:0]       RTY_LIMIT = 3'(MAX_RETRIES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_index;
  logic [2:0]       r_retry;
  logic             r_i2c_start;
  logic [7:0]       r_dev;
  logic [15:0]      r_word;
  logic             r_busy;
  logic             r_init_done;
  logic             r_init_error;

  logic [15:0]      w_rom_word;
  logic             w_timeout;
  logic             w_txn_end;
  logic             w_txn_nack;

  codec_init_rom u_rom (
    .i_index (5'(r_index)),
    .o_word  (w_rom_word)
  );

`ifdef CODEC_INIT_TIMEOUT_EN
  logic [11:0] r_wdog;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_wdog <= '0;
    else if (r_state == ISSUE)
      r_wdog <= 12'(TIMEOUT_CYCLES - 1);
    else if (r_state == WAIT && r_wdog != '0)
      r_wdog <= r_wdog - 12'd1;
  end

  assign w_timeout = (r_state == WAIT) && (r_wdog == '0);
`else
  assign w_timeout = 1'b0;
`endif

  // A real i2c_done wins over a coincident watchdog expiry.
  always_comb begin
    w_txn_end  = i2c_done || w_timeout;
    w_txn_nack = i2c_done ? i2c_ack_err : 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_index      <= '0;
      r_retry      <= '0;
      r_i2c_start  <= 1'b0;
      r_dev        <= '0;
      r_word       <= '0;
      r_busy       <= 1'b0;
      r_init_done  <= 1'b0;
      r_init_error <= 1'b0;
    end else begin
      r_i2c_start <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state      <= PWR_WAIT;
            r_cnt        <= PWR_LOAD;
            r_index      <= '0;
            r_retry      <= '0;
            r_busy       <= 1'b1;
            r_init_done  <= 1'b0;
            r_init_error <= 1'b0;
          end
        end
        PWR_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= ISSUE;
            r_index     <= '0;
            r_retry     <= '0;
            r_i2c_start <= 1'b1;
            r_dev       <= DEV_ADDR;
            r_word      <= w_rom_word;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (w_txn_end) begin
            if (w_txn_nack) begin
              r_retry <= r_retry + 3'd1;
            end else begin
              r_retry <= '0;
              if (r_index != IDX_LAST)
                r_index <= r_index + IDX_W'(1);
            end
            r_state <= GAP;
            r_cnt   <= GAP_LOAD;
          end
        end
        GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (r_retry == RTY_LIMIT) begin
            r_state      <= ERROR;
            r_busy       <= 1'b0;
            r_init_error <= 1'b1;
          end else if (r_index == IDX_LAST) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_init_done <= 1'b1;
          end else begin
            r_state     <= ISSUE;
            r_i2c_start <= 1'b1;
            r_dev       <= DEV_ADDR;
            r_word      <= w_rom_word;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i2c_start  = r_i2c_start;
  assign i2c_dev    = r_dev;
  assign i2c_word   = r_word;
  assign busy       = r_busy;
  assign init_done  = r_init_done;
  assign init_error = r_init_error;
  // In DONE the index has stepped one past the table; report the last entry.
  assign cur_index  = (r_state == DONE) ? 4'(NUM_REGS - 1) : 4'(r_index);

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Scoreboard bench: a table-walk model predicts the write sequence, an I2C engine model answers.
module tb_codec_init_sequencer;

  localparam int         NUM_REGS = 10;
  localparam logic [7:0] DEV      = 8'h34;
  localparam int         PWR      = 20;
  localparam int         GAP      = 4;
  localparam int         MAXR     = 3;
  localparam int         TMO      = 4096;
  localparam int         NONE     = 99;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        i2c_start;
  logic [7:0]  i2c_dev;
  logic [15:0] i2c_word;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_err = 1'b0;
  logic        busy, init_done, init_error;
  logic [3:0]  cur_index;

  codec_init_sequencer #(
    .NUM_REGS(NUM_REGS), .DEV_ADDR(DEV), .PWR_WAIT_CYCLES(PWR),
    .GAP_CYCLES(GAP), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .i2c_start(i2c_start), .i2c_dev(i2c_dev), .i2c_word(i2c_word),
    .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err),
    .busy(busy), .init_done(init_done), .init_error(init_error),
    .cur_index(cur_index)
  );

  always #5 clk = ~clk;

  // Codec bring-up table as documented for the board.
  logic [15:0] rom_ref [NUM_REGS] = '{16'h1E00, 16'h0C00, 16'h0117, 16'h0217, 16'h0579,
                                      16'h0812, 16'h0A00, 16'h0E42, 16'h1000, 16'h1201};

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  logic [15:0] exp_q [$];
  bit exp_err;
  int exp_idx, exp_total;
  int nack_entry = NONE, nack_count = 0;
  int run_id = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
  int starts_total = 0, last_issue_cyc = 0, mon_run = 0, eng_run = 0;
  bit engine_en = 1'b1, tmo_mode = 1'b0;
  int att [NUM_REGS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [15:0] w);
    for (int i = 0; i < NUM_REGS; i++)
      if (rom_ref[i] == w) return i;
    return -1;
  endfunction

  // Reference: each entry is attempted until ACKed or MAX retries are used up.
  task automatic build_exp(input int ne, input int nc);
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = NUM_REGS - 1;
    for (int e = 0; e < NUM_REGS; e++) begin
      int tries;
      tries = (e != ne) ? 1 : ((nc >= MAXR) ? MAXR : nc + 1);
      for (int k = 0; k < tries; k++) exp_q.push_back(rom_ref[e]);
      if (e == ne && nc >= MAXR) begin
        exp_err = 1'b1;
        exp_idx = e;
        break;
      end
    end
    exp_total = exp_q.size();
  endtask

  // Monitor: pops the scoreboard on every i2c_start and checks issue timing.
  always @(negedge clk) begin
    if (reset_n && i2c_start) begin
      int exp_c;
      logic [15:0] w;
      starts_total++;
      if (mon_run != run_id) begin
        mon_run = run_id;
        exp_c = start_cyc + PWR + 1;
      end else if (tmo_mode) begin
        exp_c = last_issue_cyc + TMO + GAP + 1;
      end else begin
        exp_c = done_cyc + GAP + 1;
      end
      last_issue_cyc = cyc;
      check("issue_latency", cyc, exp_c);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_i2c_start: got word %h, expected none", i2c_word);
      end else begin
        w = exp_q.pop_front();
        check("i2c_word", {16'h0, i2c_word}, {16'h0, w});
        check("i2c_dev", {24'h0, i2c_dev}, {24'h0, DEV});
      end
    end
  end

  // I2C engine model: answers each request after a random delay, NACKing per plan.
  always begin
    @(negedge clk);
    if (eng_run != run_id) begin
      eng_run = run_id;
      for (int i = 0; i < NUM_REGS; i++) att[i] = 0;
    end
    if (i2c_start && engine_en) begin
      int ent, dly;
      bit nack;
      ent  = lookup(i2c_word);
      dly  = int'($urandom_range(2, 6));
      nack = (ent == nack_entry) && (att[ent] < nack_count);
      if (ent >= 0) att[ent]++;
      repeat (dly) @(negedge clk);
      i2c_done    = 1'b1;
      i2c_ack_err = nack;
      done_cyc    = cyc;
      done_cnt++;
      @(negedge clk);
      i2c_done    = 1'b0;
      i2c_ack_err = 1'($urandom_range(0, 1));
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    run_id++;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", init_done, 0);
    check("error_cleared", init_error, 0);
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && !(init_done || init_error); i++) @(negedge clk);
    check("sequence_finished", init_done | init_error, 1);
    repeat (GAP * 4 + 30) @(negedge clk);
  endtask

  task automatic run_seq(input int ne, input int nc, input bit poke_gap, input int budget);
    int base;
    build_exp(ne, nc);
    nack_entry = ne;
    nack_count = nc;
    base = starts_total;
    pulse_start();
    if (poke_gap) begin
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 500 && done_cnt == d0; i++) @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("gap_start_index", cur_index, 1);
      check("gap_start_busy", busy, 1);
    end
    wait_end(budget);
    check("init_done", init_done, !exp_err);
    check("init_error", init_error, exp_err);
    check("busy_end", busy, 0);
    check("cur_index", cur_index, exp_idx);
    check("start_count", starts_total - base, exp_total);
    check("missing_starts", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_i2c_start", i2c_start, 0);
    check("rst_i2c_dev", i2c_dev, 0);
    check("rst_i2c_word", i2c_word, 0);
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_error", init_error, 0);
    check("rst_cur_index", cur_index, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_seq(NONE, 0, 1'b0, 4000);
    run_seq(3, 1, 1'b0, 4000);
    run_seq(5, 7, 1'b0, 4000);

    begin : reset_mid_txn
      int base;
      build_exp(NONE, 0);
      nack_entry = NONE;
      base = starts_total;
      pulse_start();
      for (int i = 0; i < 2000 && starts_total < base + 3; i++) @(negedge clk);
      check("reached_entry2", starts_total >= base + 3, 1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_i2c_start", i2c_start, 0);
      check("arst_i2c_dev", i2c_dev, 0);
      check("arst_i2c_word", i2c_word, 0);
      check("arst_busy", busy, 0);
      check("arst_cur_index", cur_index, 0);
      check("arst_done_err", {init_done, init_error}, 0);
      exp_q.delete();
      repeat (10) @(negedge clk);
      reset_n = 1'b1;
      run_seq(NONE, 0, 1'b0, 4000);
    end

    run_seq(NONE, 0, 1'b1, 4000);

    for (int r = 0; r < 4; r++)
      run_seq(int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, 4)), 1'b0, 4000);

`ifdef CODEC_INIT_TIMEOUT_EN
    engine_en = 1'b0;
    tmo_mode  = 1'b1;
    run_seq(0, MAXR, 1'b0, 3 * (TMO + GAP + 10) + 100);
    engine_en = 1'b1;
    tmo_mode  = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "global timeout");
  end

endmodule
